// File: rtl/round_robin_port_priority_pkg.sv
// Shared definitions for the round-robin port selector: index-width helper and reset selection.
package round_robin_port_priority_pkg;

   localparam int RESET_SEL = 0;

   // Index width for a given port count; never narrower than one bit.
   function automatic int calc_addr_width(input int count);
      if (count <= 2) return 1;
      return $clog2(count);
   endfunction

endpackage

// File: rtl/rr_rotate_priority_encoder.sv
// Combinational round-robin search: rotate the eligible vector past the current
// selection, take the lowest set bit, and map it back to an absolute port index.
module rr_rotate_priority_encoder
   import round_robin_port_priority_pkg::*;
#(
   parameter int PORTCOUNT     = 4,
   parameter int PORTADDRWIDTH = 2
) (
   input  logic [PORTCOUNT-1:0]     ack_vector,
   input  logic [PORTADDRWIDTH-1:0] sel,
   output logic                     valid,
   output logic [PORTADDRWIDTH-1:0] next_sel
);

   localparam logic [PORTADDRWIDTH:0] PORT_LIMIT = (PORTADDRWIDTH+1)'(PORTCOUNT);

   logic [PORTADDRWIDTH:0]     shamt;
   logic [2*PORTCOUNT-1:0]     doubled;
   logic [PORTCOUNT-1:0]       rotated;
   logic [PORTADDRWIDTH:0]     lowest;
   logic [PORTADDRWIDTH:0]     sum;

   // One extra bit on the shift amount so sel = PORTCOUNT-1 rotates by a full PORTCOUNT.
   assign shamt   = {1'b0, sel} + (PORTADDRWIDTH+1)'(1);
   assign doubled = {ack_vector, ack_vector} >> shamt;
   assign rotated = doubled[PORTCOUNT-1:0];

   always_comb begin
      valid  = 1'b0;
      lowest = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int j = PORTCOUNT - 1; j >= 0; j--) begin
         if (rotated[j]) begin
            valid  = 1'b1;
            lowest = (PORTADDRWIDTH+1)'(j);
         end
      end
   end

   // shamt + lowest is below 2*PORTCOUNT, so a single conditional subtract is a full modulo.
   always_comb begin
      sum = shamt + lowest;
      if (sum >= PORT_LIMIT) begin
         sum = sum - PORT_LIMIT;
      end
      next_sel = sum[PORTADDRWIDTH-1:0];
   end

endmodule

// File: rtl/round_robin_port_priority.sv
// Round-robin port selector: registered port index, rotating priority, hold when nothing is eligible.
module round_robin_port_priority
   import round_robin_port_priority_pkg::*;
#(
   parameter int PORTCOUNT     = 4,
   parameter int PORTADDRWIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic                     sync_rst,
   input  logic [PORTCOUNT-1:0]     PortACKVector,
   output logic [PORTADDRWIDTH-1:0] PortSelection
);

   generate
      if (PORTCOUNT < 2) begin : g_bad_count
         $error("round_robin_port_priority: PORTCOUNT must be at least 2");
      end
      if (PORTADDRWIDTH != calc_addr_width(PORTCOUNT)) begin : g_bad_width
         $error("round_robin_port_priority: PORTADDRWIDTH does not match PORTCOUNT");
      end
   endgenerate

   logic [PORTADDRWIDTH-1:0] sel;
   logic [PORTADDRWIDTH-1:0] next_sel;
   logic                     next_valid;

   rr_rotate_priority_encoder #(
      .PORTCOUNT     (PORTCOUNT),
      .PORTADDRWIDTH (PORTADDRWIDTH)
   ) u_encoder (
      .ack_vector (PortACKVector),
      .sel        (sel),
      .valid      (next_valid),
      .next_sel   (next_sel)
   );

   // No handshake: a fresh selection is taken on every enabled cycle with an eligible port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel <= PORTADDRWIDTH'(RESET_SEL);
      end else if (sync_rst) begin
         sel <= PORTADDRWIDTH'(RESET_SEL);
      end else if (clk_en && next_valid) begin
         sel <= next_sel;
      end
   end

   assign PortSelection = sel;

endmodule

// File: tb/tb_round_robin_port_priority.sv
// Directed bench for round_robin_port_priority: a 4-port and a 3-port instance.
module tb_round_robin_port_priority;

   logic       clk;
   logic       rst;
   logic       clk_en;
   logic       sync_rst;
   logic [3:0] ack;
   logic [1:0] sel;

   logic       clk_en3;
   logic       sync_rst3;
   logic [2:0] ack3;
   logic [1:0] sel3;

   int checks;
   int errors;

   round_robin_port_priority #(.PORTCOUNT(4), .PORTADDRWIDTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .sync_rst      (sync_rst),
      .PortACKVector (ack),
      .PortSelection (sel)
   );

   round_robin_port_priority #(.PORTCOUNT(3), .PORTADDRWIDTH(2)) dut3 (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en3),
      .sync_rst      (sync_rst3),
      .PortACKVector (ack3),
      .PortSelection (sel3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 ns so outputs are read away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_check(input logic [3:0] a, input string tag, input int exp);
      ack = a;
      step();
      check(tag, int'(sel), exp);
   endtask

   // Reference: walk sel+1, sel+2, ... modulo n; keep sel if nothing eligible.
   function automatic int model_next(input int cur, input logic [3:0] a, input int n);
      for (int k = 1; k <= n; k++) begin
         if (a[(cur + k) % n] === 1'b1) return (cur + k) % n;
      end
      return cur;
   endfunction

   initial begin
      int exp_sel;
      logic [3:0] a;
      logic [2:0] r3;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      clk_en    = 1'b0;
      sync_rst  = 1'b0;
      ack       = 4'b0000;
      clk_en3   = 1'b0;
      sync_rst3 = 1'b0;
      ack3      = 3'b000;

      step();
      step();
      check("reset_sel4", int'(sel), 0);
      check("reset_sel3", int'(sel3), 0);
      rst = 1'b0;

      // Async reset from Sel=3, asserted mid-cycle.
      clk_en = 1'b1;
      drive_check(4'b1000, "to3", 3);
      #2 rst = 1'b1;
      #1 check("async_rst", int'(sel), 0);
      #1 rst = 1'b0;

      // Basic rotation from Sel=0.
      drive_check(4'b0101, "rot_0101", 2);
      drive_check(4'b0110, "rot_0110", 1);
      drive_check(4'b0111, "rot_0111", 2);

      // sync_rst beats clk_en and a full vector.
      sync_rst = 1'b1;
      drive_check(4'b1111, "sync_rst", 0);
      sync_rst = 1'b0;

      // Wrap-around.
      drive_check(4'b1000, "wrap_to3", 3);
      drive_check(4'b1001, "wrap_3_1001", 0);
      drive_check(4'b0100, "wrap_to2", 2);
      drive_check(4'b0011, "wrap_2_0011", 0);
      drive_check(4'b1111, "full_1", 1);
      drive_check(4'b1111, "full_2", 2);
      drive_check(4'b1111, "full_3", 3);
      drive_check(4'b1111, "full_0", 0);

      // Hold cases.
      drive_check(4'b0100, "hold_to2", 2);
      drive_check(4'b0000, "hold_none", 2);
      drive_check(4'b0010, "hold_to1", 1);
      drive_check(4'b0010, "hold_own", 1);
      clk_en = 1'b0;
      drive_check(4'b1111, "hold_en0_a", 1);
      drive_check(4'b1111, "hold_en0_b", 1);
      clk_en = 1'b1;

      // Counting sweep from a clean Sel=0.
      sync_rst = 1'b1;
      drive_check(4'b0000, "sweep_clear", 0);
      sync_rst = 1'b0;
      exp_sel = 0;
      for (int c = 5; c < 25; c++) begin
         a = 4'(c);
         exp_sel = model_next(exp_sel, a, 4);
         drive_check(a, $sformatf("sweep_%0d", c), exp_sel);
      end

      // Three-port instance.
      clk_en3 = 1'b1;
      ack3 = 3'b100;
      step();
      check("p3_to2", int'(sel3), 2);
      ack3 = 3'b111;
      step();
      check("p3_wrap", int'(sel3), 0);
      exp_sel = 0;
      for (int i = 0; i < 40; i++) begin
         r3 = 3'($urandom_range(0, 7));
         ack3 = r3;
         exp_sel = model_next(exp_sel, {1'b0, r3}, 3);
         step();
         check($sformatf("p3_rand_%0d", i), int'(sel3), exp_sel);
         check($sformatf("p3_range_%0d", i), int'(sel3 < 2'd3), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
